sram_program_loader: RTL and testbench

Upstream stage for the SLC-3 top level that fills external SRAM with a program image before the CPU runs. It takes a byte stream (valid/ready), packs the bytes into big-endian 16-bit words, and writes them to sequential SRAM addresses using active-low CE/UB/LB/OE/WE timing. It also holds the CPU while a load is in progress. Its SRAM outputs are muxed with the CPU's memory controls ahead of the SRAM tristate buffer.

---
 rtl/sram_program_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_sram_program_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_program_loader.sv
// -----------------------------------------------------------------------------
// sram_program_loader
//
// Fills external SRAM with a program image before the SLC-3 CPU runs. Bytes
// arrive on a valid/ready stream, are packed big-endian into 16-bit words and
// written to sequential word addresses with active-low SRAM strobes. The CPU
// is held in reset for the whole load.
//
// Each word costs one SETUP cycle, WE_CYCLES cycles with WE low and one HOLD
// cycle after its second byte is accepted. The data bus is driven across all
// of them, so data is stable on both edges of WE.
//
// Parameters:
//   START_ADDR   word address of the first write of every load
//   WE_CYCLES    cycles WE is held low per write (1..15)
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         synchronous, active-low reset
//   Load_Start    single-cycle pulse starting a load (ignored while Busy)
//   Word_Count    words to load, sampled with an accepted Load_Start
//   Byte_In       stream byte
//   Byte_Valid    Byte_In is valid
//   Byte_Ready    loader accepts a byte (GET_HI / GET_LO only)
//   CE,UB,LB,OE,WE  SRAM controls, active-low (OE is always high)
//   ADDR          SRAM address {4'b0000, word address}
//   Data_Out      write data toward the SRAM tristate buffer
//   Data_Drive    tristate enable, 1 = drive the data bus
//   Busy          load in progress
//   Done          last load completed (held until the next load or reset)
//   CPU_Hold      keeps the CPU in reset, identical to Busy
//   Loaded_Count  words written in the current or last load
// -----------------------------------------------------------------------------
module sram_program_loader #(
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter int          WE_CYCLES  = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load_Start,
    input  logic [15:0] Word_Count,
    input  logic [7:0]  Byte_In,
    input  logic        Byte_Valid,
    output logic        Byte_Ready,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    output logic [15:0] Data_Out,
    output logic        Data_Drive,
    output logic        Busy,
    output logic        Done,
    output logic        CPU_Hold,
    output logic [15:0] Loaded_Count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_HI,
        ST_GET_LO,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Last value of the WE-low cycle counter before leaving WRITE.
    localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [15:0] count_reg, count_next;     // latched Word_Count
    logic [15:0] addr_reg, addr_next;       // current word address
    logic [15:0] loaded_reg, loaded_next;   // words written so far
    logic [3:0]  we_cnt_reg, we_cnt_next;   // cycles spent in WRITE

    logic [15:0] loaded_inc;
    assign loaded_inc = loaded_reg + 16'd1;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg  <= ST_IDLE;
            count_reg  <= 16'd0;
            addr_reg   <= 16'd0;
            loaded_reg <= 16'd0;
            we_cnt_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            addr_reg   <= addr_next;
            loaded_reg <= loaded_next;
            we_cnt_reg <= we_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Byte lanes of the write word. Lane 1 (high byte) is captured in GET_HI,
    // lane 0 (low byte) in GET_LO; Byte_Ready is 1 in both, so a transfer there
    // is just Byte_Valid. The lanes hold their value through SETUP/WRITE/HOLD.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            localparam state_t CAPTURE_STATE = (gi == 1) ? ST_GET_HI : ST_GET_LO;
            logic [7:0] lane_reg;

            always_ff @(posedge Clk) begin
                if (!Reset) begin
                    lane_reg <= 8'd0;
                end else if ((state_reg == CAPTURE_STATE) && Byte_Valid) begin
                    lane_reg <= Byte_In;
                end
            end
        end
    endgenerate

    assign Data_Out = {g_lane[1].lane_reg, g_lane[0].lane_reg};
    assign ADDR     = {4'b0000, addr_reg};
    assign OE       = 1'b1;
    assign Loaded_Count = loaded_reg;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        addr_next   = addr_reg;
        loaded_next = loaded_reg;
        we_cnt_next = we_cnt_reg;

        Byte_Ready = 1'b0;
        CE         = 1'b1;
        UB         = 1'b1;
        LB         = 1'b1;
        WE         = 1'b1;
        Data_Drive = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        CPU_Hold   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                Done = (state_reg == ST_DONE);
                if (Load_Start) begin
                    loaded_next = 16'd0;
                    if (Word_Count == 16'd0) begin
                        // Empty image: finish immediately, no SRAM traffic.
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_GET_HI;
                        count_next = Word_Count;
                        addr_next  = START_ADDR;
                    end
                end
            end

            ST_GET_HI: begin
                Busy       = 1'b1;
                Byte_Ready = 1'b1;
                if (Byte_Valid) begin
                    state_next = ST_GET_LO;
                end
            end

            ST_GET_LO: begin
                Busy       = 1'b1;
                Byte_Ready = 1'b1;
                if (Byte_Valid) begin
                    state_next = ST_SETUP;
                end
            end

            ST_SETUP: begin
                // Address and data settle before WE falls.
                Busy        = 1'b1;
                CE          = 1'b0;
                UB          = 1'b0;
                LB          = 1'b0;
                Data_Drive  = 1'b1;
                we_cnt_next = 4'd0;
                state_next  = ST_WRITE;
            end

            ST_WRITE: begin
                Busy       = 1'b1;
                CE         = 1'b0;
                UB         = 1'b0;
                LB         = 1'b0;
                WE         = 1'b0;
                Data_Drive = 1'b1;
                if (we_cnt_reg == WE_LAST) begin
                    state_next = ST_HOLD;
                end else begin
                    we_cnt_next = we_cnt_reg + 4'd1;
                end
            end

            ST_HOLD: begin
                // WE has risen; keep chip selected and data driven for hold time.
                Busy        = 1'b1;
                CE          = 1'b0;
                UB          = 1'b0;
                LB          = 1'b0;
                Data_Drive  = 1'b1;
                loaded_next = loaded_inc;
                addr_next   = addr_reg + 16'd1;   // wraps 0xFFFF -> 0x0000
                if (loaded_inc == count_reg) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_GET_HI;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        CPU_Hold = Busy;
    end

endmodule

// File: tb/tb_sram_program_loader.sv
// -----------------------------------------------------------------------------
// tb_sram_program_loader
//
// Directed bench for sram_program_loader. Two instances share all inputs:
// dut_a uses START_ADDR = 0, dut_w uses START_ADDR = 16'hFFFF for the address
// wrap case. A monitor records every SRAM write (address, data, WE-low length,
// SETUP/HOLD framing, stability while WE is low) for each instance, and the
// stimulus sequence compares those records against hand-computed values.
// -----------------------------------------------------------------------------
module tb_sram_program_loader;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        Load_Start;
    logic [15:0] Word_Count;
    logic [7:0]  Byte_In;
    logic        Byte_Valid;

    logic        byte_ready_s [2];
    logic        ce_s         [2];
    logic        ub_s         [2];
    logic        lb_s         [2];
    logic        oe_s         [2];
    logic        we_s         [2];
    logic [19:0] addr_s       [2];
    logic [15:0] data_out_s   [2];
    logic        data_drive_s [2];
    logic        busy_s       [2];
    logic        done_s       [2];
    logic        cpu_hold_s   [2];
    logic [15:0] loaded_s     [2];

    sram_program_loader #(.START_ADDR(16'h0000), .WE_CYCLES(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .Load_Start(Load_Start), .Word_Count(Word_Count),
        .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(byte_ready_s[0]),
        .CE(ce_s[0]), .UB(ub_s[0]), .LB(lb_s[0]), .OE(oe_s[0]), .WE(we_s[0]),
        .ADDR(addr_s[0]), .Data_Out(data_out_s[0]), .Data_Drive(data_drive_s[0]),
        .Busy(busy_s[0]), .Done(done_s[0]), .CPU_Hold(cpu_hold_s[0]),
        .Loaded_Count(loaded_s[0])
    );

    sram_program_loader #(.START_ADDR(16'hFFFF), .WE_CYCLES(2)) dut_w (
        .Clk(Clk), .Reset(Reset), .Load_Start(Load_Start), .Word_Count(Word_Count),
        .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(byte_ready_s[1]),
        .CE(ce_s[1]), .UB(ub_s[1]), .LB(lb_s[1]), .OE(oe_s[1]), .WE(we_s[1]),
        .ADDR(addr_s[1]), .Data_Out(data_out_s[1]), .Data_Drive(data_drive_s[1]),
        .Busy(busy_s[1]), .Done(done_s[1]), .CPU_Hold(cpu_hold_s[1]),
        .Loaded_Count(loaded_s[1])
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // ---------------------------------------------------------------------
    // Write monitor (sampled on the falling edge)
    // ---------------------------------------------------------------------
    logic [19:0] wr_addr   [2][32];
    logic [15:0] wr_data   [2][32];
    int          wr_len    [2][32];
    logic        wr_setup  [2][32];
    logic        wr_hold   [2][32];
    logic        wr_stable [2][32];
    int          nwr        [2] = '{0, 0};
    int          ready_seen [2] = '{0, 0};
    logic        prev_we    [2] = '{1'b1, 1'b1};
    logic        prev_setup [2] = '{1'b0, 1'b0};

    always @(negedge Clk) begin
        for (int d = 0; d < 2; d++) begin
            if (byte_ready_s[d] === 1'b1) ready_seen[d]++;
            if (we_s[d] === 1'b0) begin
                if (prev_we[d] === 1'b1) begin
                    if (nwr[d] < 32) begin
                        wr_addr[d][nwr[d]]   = addr_s[d];
                        wr_data[d][nwr[d]]   = data_out_s[d];
                        wr_len[d][nwr[d]]    = 1;
                        wr_setup[d][nwr[d]]  = prev_setup[d];
                        wr_hold[d][nwr[d]]   = 1'b0;
                        wr_stable[d][nwr[d]] = (ce_s[d] === 1'b0) && (ub_s[d] === 1'b0) &&
                                               (lb_s[d] === 1'b0) && (data_drive_s[d] === 1'b1);
                    end
                    nwr[d]++;
                end else if (nwr[d] > 0 && nwr[d] <= 32) begin
                    wr_len[d][nwr[d]-1]++;
                    wr_stable[d][nwr[d]-1] &= (addr_s[d] === wr_addr[d][nwr[d]-1]) &&
                                              (data_out_s[d] === wr_data[d][nwr[d]-1]) &&
                                              (ce_s[d] === 1'b0) && (data_drive_s[d] === 1'b1);
                end
            end else if (prev_we[d] === 1'b0 && nwr[d] > 0 && nwr[d] <= 32) begin
                wr_hold[d][nwr[d]-1] = (ce_s[d] === 1'b0) && (ub_s[d] === 1'b0) &&
                                       (lb_s[d] === 1'b0) && (data_drive_s[d] === 1'b1) &&
                                       (addr_s[d] === wr_addr[d][nwr[d]-1]);
            end
            prev_setup[d] = (we_s[d] === 1'b1) && (ce_s[d] === 1'b0) && (ub_s[d] === 1'b0) &&
                            (lb_s[d] === 1'b0) && (data_drive_s[d] === 1'b1);
            prev_we[d] = we_s[d];
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (called at posedge+1 or negedge, away from the edge)
    // ---------------------------------------------------------------------
    task automatic start_load(input logic [15:0] count);
        Load_Start = 1'b1;
        Word_Count = count;
        @(posedge Clk); #1;
        Load_Start = 1'b0;
        Word_Count = 16'h0000;
    endtask

    // Presents one byte and waits for the edge on which it is accepted.
    task automatic send_byte(input logic [7:0] b);
        logic got;
        logic taken;
        taken = 1'b0;
        Byte_In    = b;
        Byte_Valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            got = byte_ready_s[0];
            @(posedge Clk); #1;
            if (got === 1'b1) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) check("byte_accept_timeout", 32'(taken), 32'd1);
    endtask

    task automatic wait_done(input int d, input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (done_s[d] === 1'b1) break;
        end
        check(tag, 32'(done_s[d]), 32'd1);
    endtask

    task automatic check_write(input int d, input int idx, input logic [19:0] a,
                               input logic [15:0] dat, input string tag);
        check({tag, "_addr"},   32'(wr_addr[d][idx]),   32'(a));
        check({tag, "_data"},   32'(wr_data[d][idx]),   32'(dat));
        check({tag, "_we_len"}, 32'(wr_len[d][idx]),    32'd2);
        check({tag, "_setup"},  32'(wr_setup[d][idx]),  32'd1);
        check({tag, "_hold"},   32'(wr_hold[d][idx]),   32'd1);
        check({tag, "_stable"}, 32'(wr_stable[d][idx]), 32'd1);
    endtask

    int base;
    int rbase;

    initial begin
        Reset      = 1'b0;
        Load_Start = 1'b0;
        Word_Count = 16'h0000;
        Byte_In    = 8'h00;
        Byte_Valid = 1'b0;

        // ---------------- Reset with random inputs ----------------
        for (int i = 0; i < 2; i++) begin
            Load_Start = 1'($urandom);
            Word_Count = 16'($urandom);
            Byte_In    = 8'($urandom);
            Byte_Valid = 1'($urandom);
            @(posedge Clk); #1;
        end
        Load_Start = 1'b0;
        Word_Count = 16'h0000;
        Byte_In    = 8'h00;
        Byte_Valid = 1'b0;
        @(negedge Clk);
        check("rst_ctl_ce_ub_lb_oe_we", 32'({ce_s[0], ub_s[0], lb_s[0], oe_s[0], we_s[0]}), 32'h1F);
        check("rst_addr",     32'(addr_s[0]),       32'h0);
        check("rst_data",     32'(data_out_s[0]),   32'h0);
        check("rst_drive_busy_done_hold_ready",
              32'({data_drive_s[0], busy_s[0], done_s[0], cpu_hold_s[0], byte_ready_s[0]}), 32'h0);
        check("rst_loaded",   32'(loaded_s[0]),     32'h0);
        check("rst_w_addr",   32'(addr_s[1]),       32'h0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // ---------------- Zero count ----------------
        base  = nwr[0];
        rbase = ready_seen[0];
        check("zero_done_before", 32'(done_s[0]), 32'd0);
        start_load(16'd0);
        @(negedge Clk);
        check("zero_done",   32'(done_s[0]),   32'd1);
        check("zero_loaded", 32'(loaded_s[0]), 32'd0);
        check("zero_busy",   32'(busy_s[0]),   32'd0);
        repeat (3) @(negedge Clk);
        check("zero_no_write", 32'(nwr[0] - base),        32'd0);
        check("zero_no_ready", 32'(ready_seen[0] - rbase), 32'd0);

        // ---------------- Basic load: 2 words ----------------
        base = nwr[0];
        start_load(16'd2);
        @(negedge Clk);
        check("basic_busy",     32'(busy_s[0]),     32'd1);
        check("basic_cpu_hold", 32'(cpu_hold_s[0]), 32'd1);
        check("basic_done_clr", 32'(done_s[0]),     32'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        Byte_Valid = 1'b0;
        wait_done(0, "basic_done");
        check("basic_nwrites", 32'(nwr[0] - base), 32'd2);
        check_write(0, base,     20'h00000, 16'h1234, "basic_w0");
        check_write(0, base + 1, 20'h00001, 16'h5678, "basic_w1");
        check("basic_loaded",   32'(loaded_s[0]),     32'd2);
        check("basic_cpu_free", 32'(cpu_hold_s[0]),   32'd0);
        check("basic_idle_bus", 32'({data_drive_s[0], ce_s[0], we_s[0]}), 32'b011);

        // ---------------- Stalled stream: 1 word ----------------
        base = nwr[0];
        start_load(16'd1);
        send_byte(8'hAB);
        Byte_Valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("stall_ready", 32'(byte_ready_s[0]), 32'd1);
            check("stall_we",    32'(we_s[0]),         32'd1);
            check("stall_drive", 32'(data_drive_s[0]), 32'd0);
            @(posedge Clk); #1;
        end
        send_byte(8'hCD);
        Byte_Valid = 1'b0;
        wait_done(0, "stall_done");
        check("stall_nwrites", 32'(nwr[0] - base), 32'd1);
        check_write(0, base, 20'h00000, 16'hABCD, "stall_w0");
        check("stall_loaded", 32'(loaded_s[0]), 32'd1);

        // ---------------- Reset in the first WRITE cycle ----------------
        base = nwr[0];
        start_load(16'd1);
        send_byte(8'h5A);
        send_byte(8'hA5);
        Byte_Valid = 1'b0;
        @(posedge Clk); #1;                // SETUP -> WRITE
        @(negedge Clk);
        check("midrst_we_low", 32'(we_s[0]), 32'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_we",    32'(we_s[0]),   32'd1);
        check("midrst_busy",  32'(busy_s[0]), 32'd0);
        check("midrst_flags", 32'({cpu_hold_s[0], done_s[0], data_drive_s[0], ce_s[0]}), 32'b0001);
        check("midrst_addr",  32'(addr_s[0]), 32'h0);
        check("midrst_one_short_write", 32'(nwr[0] - base), 32'd1);
        check("midrst_we_len", 32'(wr_len[0][base]), 32'd1);
        repeat (2) @(negedge Clk);
        check("midrst_no_more_writes", 32'(nwr[0] - base), 32'd1);
        base = nwr[0];
        start_load(16'd1);
        send_byte(8'h9A);
        send_byte(8'hBC);
        Byte_Valid = 1'b0;
        wait_done(0, "restart_done");
        check("restart_nwrites", 32'(nwr[0] - base), 32'd1);
        check_write(0, base, 20'h00000, 16'h9ABC, "restart_w0");

        // ---------------- Address wrap + ignored Load_Start ----------------
        base = nwr[1];
        start_load(16'd2);
        send_byte(8'h11);                  // now in GET_LO
        Load_Start = 1'b1;
        Word_Count = 16'd5;
        send_byte(8'h22);
        Load_Start = 1'b0;
        Word_Count = 16'd0;
        send_byte(8'h33);
        send_byte(8'h44);
        Byte_Valid = 1'b0;
        wait_done(1, "wrap_done");
        check("wrap_nwrites", 32'(nwr[1] - base), 32'd2);
        check_write(1, base,     20'h0FFFF, 16'h1122, "wrap_w0");
        check_write(1, base + 1, 20'h00000, 16'h3344, "wrap_w1");
        check("wrap_loaded", 32'(loaded_s[1]), 32'd2);
        check("wrap_busy",   32'(busy_s[1]),   32'd0);
        repeat (3) @(negedge Clk);
        check("wrap_no_extra_writes", 32'(nwr[1] - base), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
